// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and an iterative shifter
module alu_mc #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] STEP = SHIFT_STEP[SW:0];
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t            state;
    logic [WIDTH-1:0]  work, alu_res, shifted, sra_v;
    logic [SW-1:0]     rem, shamt;
    logic [SW:0]       s;
    logic [1:0]        sop;
    logic              ill, is_shift, last;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign shamt     = b[SW-1:0];
    assign is_shift  = op[3:2] == 2'b10 && op[1:0] != 2'b11;
    always_comb begin
        alu_res = '0;
        ill     = 1'b0;
        case (op)
            4'b0000: alu_res = a + b;
            4'b0001: alu_res = a - b;
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a ^ b;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            // only reached for shamt == 0; nonzero shifts go through SHIFT
            4'b1000, 4'b1001, 4'b1010: alu_res = a;
            default: ill = 1'b1;
        endcase
    end
    assign s       = ({1'b0, rem} > STEP) ? STEP : {1'b0, rem};
    assign last    = {1'b0, rem} <= STEP;
    // the sign bit of work never changes during SRA, so it always fills with a[WIDTH-1]
    assign sra_v   = $signed(work) >>> s;
    assign shifted = sop == 2'b00 ? work << s : sop == 2'b10 ? sra_v : work >> s;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            work    <= '0;
            rem     <= '0;
            sop     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (is_shift && shamt != '0) begin
                        work  <= a;
                        rem   <= shamt;
                        sop   <= op[1:0];
                        state <= SHIFT;
                    end else begin
                        result  <= alu_res;
                        zero    <= alu_res == '0;
                        illegal <= ill;
                        state   <= DONE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem - s[SW-1:0];
                    if (last) begin
                        result  <= shifted;
                        zero    <= shifted == '0;
                        illegal <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU.
- Generic operand width and a 4-bit opcode space. The five existing opcodes keep their encodings; XOR, SLTU and shifts are new.
- Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle. All other ops complete in one cycle.
- Sits between the decode/operand-fetch stage and writeback. Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 8.
- SHIFT_STEP, 4, maximum shift distance per cycle; power of two, 1..WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, shamt = b[$clog2(WIDTH)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- zero  out  1  result == 0.
- illegal  out  1  opcode was undefined.

Behaviour:
- Opcodes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 1000, SRL 1001, SRA 1010.
  - All other codes are undefined: result 0, illegal=1, zero=1, latency 1.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. SLT is signed two's-complement, SLTU unsigned; both return 0 or 1 zero-extended.
- Shift fill: SRA fills with the original a[WIDTH-1]; SLL/SRL fill with 0. Upper bits of b above shamt are ignored.
- FSM states IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; in_ready=1, out_valid=0, result=0, zero=0, illegal=0.
  - Any in-flight shift is discarded. No output is produced for it.
- IDLE:
  - in_ready=1.
  - Accept on an edge where in_valid && in_ready.
  - Non-shift op, or shift with shamt==0: result, zero and illegal are registered on that edge and state goes to DONE. For shamt==0, result = a.
  - Shift with shamt>0: load working register = a, remaining = shamt, latch the op; state goes to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge shifts the working register by s = min(SHIFT_STEP, remaining) and sets remaining -= s.
  - When remaining <= SHIFT_STEP, that edge also goes to DONE and registers result/zero.
- DONE:
  - out_valid=1, in_ready=0. result, zero and illegal are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid falls.
  - No back-to-back accept: a new request can only be accepted in the cycle after the result handshake.
- Latency (accept edge to first cycle with out_valid=1):
  - 1 cycle for non-shift ops and for shamt=0.
  - 1 + ceil(shamt/SHIFT_STEP) cycles for shifts.
  - Maximum is 1 + WIDTH/SHIFT_STEP.
- Inputs op/a/b are sampled only on the accept edge. Changes afterwards have no effect.
- out_ready is ignored outside DONE.
- in_valid while busy is not accepted. The requester must hold its request; the ALU has no buffering.
- SHIFT_STEP == WIDTH degenerates to 2-cycle shifts. The shifter must still be correct.

Test Plan:
- Reset, WIDTH=32: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, result=0 throughout; no accept during reset.
- ADD wrap: a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid exactly 1 cycle after accept; result=0, zero=1. SUB a=5, b=7 -> 0xFFFFFFFE.
- SLT vs SLTU: a=0x80000000, b=1 -> SLT result=1, SLTU result=0.
- Shift latency, SHIFT_STEP=4:
  - SRA a=0x80000000, shamt=10 -> out_valid 4 cycles after accept; result=0xFFE00000.
  - SLL a=1, shamt=0 -> 1 cycle; result=1.
  - SRL a=0xFFFFFFFF, b=0x3F (shamt=31) -> 9 cycles; result=1.
- Backpressure and busy: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a concurrent in_valid is not accepted. After out_ready=1, the pending request is accepted on the next edge.
- Illegal op 0111 -> illegal=1, result=0, zero=1, 1-cycle latency.
- Reset mid-operation: drop rst_n during SHIFT (shamt=31) -> next cycle IDLE, out_valid stays 0, no result emitted.
